// File: rtl/sdc_host_resp_pkg.sv
// Shared definitions for the SDRAM-style host responder.
// State encoding, default timing constants and counter helpers.
package sdc_host_resp_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_ACT,
    ST_WR,
    ST_RD_WAIT,
    ST_RD,
    ST_PRE
  } state_t;

  localparam int SDC_MEM_AW   = 8;
  localparam int SDC_INIT_CYC = 16;
  localparam int SDC_TRCD     = 2;
  localparam int SDC_CAS      = 2;
  localparam int SDC_TRP      = 2;

  localparam int CNT_W = 16;

  // Terminal count for a phase lasting n cycles.
  function automatic logic [CNT_W-1:0] cyc_last(input int n);
    return CNT_W'(n - 1);
  endfunction

endpackage

// File: rtl/sdc_resp_mem.sv
// Word store: synchronous byte-masked write, registered read.
// Read register holds its value when no read is issued.
module sdc_resp_mem #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic          re,
  input  logic [AW-1:0] adr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[adr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[adr];
    end
  end

endmodule

// File: rtl/sdc_host_resp.sv
// Host-side responder emulating an SDRAM controller burst protocol
// over an internal word store.
module sdc_host_resp
  import sdc_host_resp_pkg::*;
#(
  parameter int MEM_AW   = SDC_MEM_AW,
  parameter int INIT_CYC = SDC_INIT_CYC,
  parameter int TRCD     = SDC_TRCD,
  parameter int CAS      = SDC_CAS,
  parameter int TRP      = SDC_TRP
) (
  input  logic              mclk,
  input  logic              s_reset,
  input  logic              sdr_en,
  input  logic              sdr_req,
  input  logic [MEM_AW-1:0] sdr_req_adr,
  input  logic [1:0]        sdr_req_len,
  input  logic              sdr_req_wr_n,
  input  logic [31:0]       sdr_wr_data,
  input  logic [3:0]        sdr_wr_en_n,
  output logic              sdr_req_ack,
  output logic              sdr_wr_next,
  output logic              sdr_rd_valid,
  output logic [31:0]       sdr_rd_data,
  output logic              sdr_init_done
);

  state_t state;
  state_t state_nxt;

  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [CNT_W-1:0]  beat_last;
  logic [MEM_AW-1:0] adr_q;
  logic [1:0]        len_q;
  logic              wr_n_q;
  logic              init_nxt;
  logic              ack_nxt;
  logic              take;
  logic              mem_we;
  logic              mem_re;

  assign beat_last = CNT_W'(len_q);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    init_nxt  = sdr_init_done;
    ack_nxt   = 1'b0;
    take      = 1'b0;
    unique case (state)
      ST_INIT: begin
        if (cnt == cyc_last(INIT_CYC)) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
          init_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_IDLE: begin
        if (sdr_req && sdr_en && sdr_init_done) begin
          ack_nxt   = 1'b1;
          take      = 1'b1;
          state_nxt = ST_ACT;
          cnt_nxt   = '0;
        end
      end
      ST_ACT: begin
        if (cnt == cyc_last(TRCD)) begin
          state_nxt = wr_n_q ? ST_RD_WAIT : ST_WR;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_WR: begin
        if (cnt == beat_last) begin
          state_nxt = ST_PRE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_RD_WAIT: begin
        if (cnt == cyc_last(CAS)) begin
          state_nxt = ST_RD;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_RD: begin
        if (cnt == beat_last) begin
          state_nxt = ST_PRE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_PRE: begin
        if (cnt == cyc_last(TRP)) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = ST_INIT;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Reads are issued one cycle ahead so the registered word lands
  // in the same cycle that rd_valid is high.
  assign mem_we = (state == ST_WR) && !s_reset;
  assign mem_re = (state_nxt == ST_RD) && !s_reset;

  always_ff @(posedge mclk) begin
    if (s_reset) begin
      state         <= ST_INIT;
      cnt           <= '0;
      sdr_init_done <= 1'b0;
      sdr_req_ack   <= 1'b0;
      sdr_wr_next   <= 1'b0;
      sdr_rd_valid  <= 1'b0;
      adr_q         <= '0;
      len_q         <= '0;
      wr_n_q        <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      sdr_init_done <= init_nxt;
      sdr_req_ack   <= ack_nxt;
      sdr_wr_next   <= (state_nxt == ST_WR);
      sdr_rd_valid  <= (state_nxt == ST_RD);
      if (take) begin
        adr_q  <= sdr_req_adr;
        len_q  <= sdr_req_len;
        wr_n_q <= sdr_req_wr_n;
      end else if (mem_we || mem_re) begin
        adr_q <= adr_q + MEM_AW'(1);
      end
    end
  end

  sdc_resp_mem #(
    .AW (MEM_AW)
  ) u_mem (
    .clk   (mclk),
    .rst   (s_reset),
    .we    (mem_we),
    .be    (~sdr_wr_en_n),
    .re    (mem_re),
    .adr   (adr_q),
    .wdata (sdr_wr_data),
    .rdata (sdr_rd_data)
  );

endmodule

// File: tb/tb_sdc_host_resp.sv
// Directed bench for sdc_host_resp with a read-data scoreboard.
// Stimulus pushes expected words; a negedge monitor pops and compares.
module tb_sdc_host_resp;

  logic        mclk;
  logic        s_reset;
  logic        sdr_en;
  logic        sdr_req;
  logic [7:0]  sdr_req_adr;
  logic [1:0]  sdr_req_len;
  logic        sdr_req_wr_n;
  logic [31:0] sdr_wr_data;
  logic [3:0]  sdr_wr_en_n;
  logic        sdr_req_ack;
  logic        sdr_wr_next;
  logic        sdr_rd_valid;
  logic [31:0] sdr_rd_data;
  logic        sdr_init_done;

  int          compared = 0;
  int          mismatched = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_rd = '0;
  bit          rst_pend = 0;

  sdc_host_resp dut (
    .mclk          (mclk),
    .s_reset       (s_reset),
    .sdr_en        (sdr_en),
    .sdr_req       (sdr_req),
    .sdr_req_adr   (sdr_req_adr),
    .sdr_req_len   (sdr_req_len),
    .sdr_req_wr_n  (sdr_req_wr_n),
    .sdr_wr_data   (sdr_wr_data),
    .sdr_wr_en_n   (sdr_wr_en_n),
    .sdr_req_ack   (sdr_req_ack),
    .sdr_wr_next   (sdr_wr_next),
    .sdr_rd_valid  (sdr_rd_valid),
    .sdr_rd_data   (sdr_rd_data),
    .sdr_init_done (sdr_init_done)
  );

  initial begin
    mclk = 1'b0;
    forever #5 mclk = ~mclk;
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] want);
    compared++;
    if (act !== want) begin
      mismatched++;
      $display("FAIL %s: got %h, want %h", name, act, want);
    end
  endtask

  always @(negedge mclk) begin
    if (rst_pend) last_rd = '0;
    rst_pend = s_reset;
    chk("onehot_strobes",
        {31'b0, $onehot0({sdr_req_ack, sdr_wr_next, sdr_rd_valid})}, 1);
    if (sdr_rd_valid) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL rd_unexpected: got beat %h, want no beat",
                 sdr_rd_data);
      end else begin
        chk("rd_data", sdr_rd_data, exp_q.pop_front());
      end
      last_rd = sdr_rd_data;
    end else if (!s_reset) begin
      chk("rd_hold", sdr_rd_data, last_rd);
    end
  end

  task automatic step();
    @(posedge mclk);
    #1;
  endtask

  task automatic wait_init();
    int n;
    bit acked;
    n = 0;
    acked = 0;
    while (!sdr_init_done && n < 40) begin
      step();
      n++;
      if (sdr_req_ack) acked = 1;
    end
    chk("init_latency", n, 16);
    chk("ack_before_init", {31'b0, acked}, 0);
  endtask

  task automatic xfer(input bit wr_n, input logic [7:0] a,
                      input logic [1:0] l,
                      input logic [31:0] d0, input logic [31:0] d1,
                      input logic [31:0] d2, input logic [31:0] d3,
                      input logic [3:0] ben, input bit drop_en);
    logic [31:0] w[4];
    int n;
    int k;
    w[0] = d0;
    w[1] = d1;
    w[2] = d2;
    w[3] = d3;
    sdr_en       = 1'b1;
    sdr_req      = 1'b1;
    sdr_req_wr_n = wr_n;
    sdr_req_adr  = a;
    sdr_req_len  = l;
    sdr_wr_en_n  = ben;
    n = 0;
    do begin
      step();
      n++;
    end while (!sdr_req_ack && n < 40);
    chk("ack_seen", {31'b0, sdr_req_ack}, 1);
    sdr_req = 1'b0;
    if (!sdr_req_ack) return;
    if (drop_en) sdr_en = 1'b0;
    if (wr_n) begin
      for (int i = 0; i <= int'(l); i++) exp_q.push_back(w[i]);
      n = 0;
      while (!sdr_rd_valid && n < 20) begin
        step();
        n++;
      end
      chk("rd_latency", n, 4);
      k = 0;
      while (sdr_rd_valid && k < 8) begin
        step();
        k++;
      end
      chk("rd_beats", k, int'(l) + 1);
      chk("sb_drained", exp_q.size(), 0);
    end else begin
      n = 0;
      while (!sdr_wr_next && n < 20) begin
        step();
        n++;
      end
      chk("wr_latency", n, 2);
      k = 0;
      while (sdr_wr_next && k < 8) begin
        if (k < 4) sdr_wr_data = w[k];
        step();
        k++;
      end
      chk("wr_beats", k, int'(l) + 1);
    end
    sdr_en = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  acked;
    s_reset      = 1'b1;
    sdr_en       = 1'b1;
    sdr_req      = 1'b1;
    sdr_req_wr_n = 1'b0;
    sdr_req_adr  = 8'h10;
    sdr_req_len  = 2'd0;
    sdr_wr_data  = 32'hA5A5_5A5A;
    sdr_wr_en_n  = 4'h0;
    repeat (3) @(posedge mclk);
    #1;
    chk("rst_init_done", {31'b0, sdr_init_done}, 0);
    chk("rst_ack", {31'b0, sdr_req_ack}, 0);
    chk("rst_rd_data", sdr_rd_data, 32'h0);
    s_reset = 1'b0;
    wait_init();
    sdr_req = 1'b0;
    step();

    xfer(1'b0, 8'h10, 2'd0, 32'hA5A5_5A5A, 0, 0, 0, 4'h0, 1'b0);
    xfer(1'b1, 8'h10, 2'd0, 32'hA5A5_5A5A, 0, 0, 0, 4'h0, 1'b0);

    xfer(1'b0, 8'h20, 2'd0, 32'hFFFF_FFFF, 0, 0, 0, 4'h0, 1'b0);
    xfer(1'b0, 8'h20, 2'd0, 32'h0000_0000, 0, 0, 0, 4'b1010, 1'b0);
    xfer(1'b1, 8'h20, 2'd0, 32'hFF00_FF00, 0, 0, 0, 4'h0, 1'b0);

    xfer(1'b0, 8'hFE, 2'd3, 32'd1, 32'd2, 32'd3, 32'd4, 4'h0, 1'b0);
    xfer(1'b1, 8'hFE, 2'd3, 32'd1, 32'd2, 32'd3, 32'd4, 4'h0, 1'b1);
    xfer(1'b1, 8'h00, 2'd1, 32'd3, 32'd4, 0, 0, 4'h0, 1'b0);

    sdr_en       = 1'b0;
    sdr_req      = 1'b1;
    sdr_req_wr_n = 1'b0;
    sdr_req_adr  = 8'h30;
    sdr_req_len  = 2'd0;
    sdr_wr_data  = 32'h1234_5678;
    sdr_wr_en_n  = 4'h0;
    acked = 0;
    repeat (5) begin
      step();
      if (sdr_req_ack) acked = 1;
    end
    chk("ack_gated_by_en", {31'b0, acked}, 0);
    sdr_en = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (!sdr_req_ack && n < 20);
    chk("ack_after_en", n, 1);
    n = 0;
    do begin
      step();
      n++;
    end while (!sdr_req_ack && n < 40);
    chk("ack_gap_b2b", n, 6);
    sdr_req = 1'b0;
    repeat (8) step();
    xfer(1'b1, 8'h30, 2'd0, 32'h1234_5678, 0, 0, 0, 4'h0, 1'b0);

    sdr_req      = 1'b1;
    sdr_req_wr_n = 1'b1;
    sdr_req_adr  = 8'hFE;
    sdr_req_len  = 2'd3;
    n = 0;
    do begin
      step();
      n++;
    end while (!sdr_req_ack && n < 40);
    chk("ack_mid_rd", {31'b0, sdr_req_ack}, 1);
    sdr_req = 1'b0;
    for (int i = 1; i <= 4; i++) exp_q.push_back(32'(i));
    n = 0;
    while (!sdr_rd_valid && n < 20) begin
      step();
      n++;
    end
    step();
    chk("rd_beat2_valid", {31'b0, sdr_rd_valid}, 1);
    s_reset = 1'b1;
    step();
    s_reset = 1'b0;
    chk("rd_valid_after_rst", {31'b0, sdr_rd_valid}, 0);
    chk("init_done_after_rst", {31'b0, sdr_init_done}, 0);
    exp_q.delete();
    wait_init();
    step();
    xfer(1'b1, 8'h20, 2'd0, 32'hFF00_FF00, 0, 0, 0, 4'h0, 1'b0);

    repeat (3) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
